// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB slave mux front-end.
// Holds the FSM state enum, error-cause codes and AXI response codes.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_BACKEND = 2'd1;
    localparam logic [1:0] CAUSE_DECODE  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [1:0] AXI_OKAY   = 2'd0;
    localparam logic [1:0] AXI_EXOKAY = 2'd1;
    localparam logic [1:0] AXI_SLVERR = 2'd2;
    localparam logic [1:0] AXI_DECERR = 2'd3;

    function automatic logic resp_is_err(input logic [1:0] r);
        return !(r == AXI_OKAY || r == AXI_EXOKAY);
    endfunction

endpackage

// File: rtl/apb_ifc.sv
// APB bus bundle with master and slave views.
// Carries psel/penable/pwrite/paddr/pwdata/pstrb/pprot and prdata/pready/pslverr.
interface apb_ifc #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [2:0]      pprot;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_wdt.sv
// Loadable down-counter watchdog: load_i arms it with LIMIT, en_i counts,
// clr_i zeroes it; expire_o is high in the LIMIT-th enabled cycle after load.
module apb_wdt #(
    parameter int LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    if (LIMIT > 0) begin : g_wdt
        localparam int W = $clog2(LIMIT + 1);

        logic [W-1:0] cnt_q;
        logic [W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (load_i) begin
                cnt_d = W'(LIMIT);
            end else if (en_i && cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Loaded with LIMIT, so reaching 1 marks the last allowed cycle.
        assign expire_o = en_i && (cnt_q == W'(1));
    end else begin : g_off
        logic unused_in;
        assign unused_in = ^{clk_i, rst_ni, load_i, en_i, clr_i};
        assign expire_o  = 1'b0;
    end

endmodule

// File: rtl/apb_slave_mux.sv
// APB slave front-end dispatching each transfer to one of N_CH backends.
// Ports: s_apb (APB slave), req_* (channel request), rsp_* (channel response), err_*.
module apb_slave_mux
    import apb_slave_pkg::*;
#(
    parameter int AW_APB         = 32,
    parameter int DW_APB         = 32,
    parameter int N_CH           = 2,
    parameter int CH_SEL_LSB     = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   apb_clk,
    input  logic                   sys_aresetn,
    apb_ifc.slave                  s_apb,
    output logic [N_CH-1:0]        req_valid,
    output logic                   req_write,
    output logic [AW_APB-1:0]      req_addr,
    output logic [DW_APB-1:0]      req_wdata,
    output logic [DW_APB/8-1:0]    req_be,
    output logic [2:0]             req_prot,
    input  logic [N_CH-1:0]        rsp_valid,
    input  logic [N_CH*DW_APB-1:0] rsp_rdata,
    input  logic [N_CH*2-1:0]      rsp_resp,
    output logic                   err_event,
    output logic [1:0]             err_cause
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW = DW_APB / 8;

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [N_CH-1:0]     abandoned_q, abandoned_d;
    logic [N_CH-1:0]     req_valid_q, req_valid_d;
    logic                req_write_q, req_write_d;
    logic [AW_APB-1:0]   req_addr_q, req_addr_d;
    logic [DW_APB-1:0]   req_wdata_q, req_wdata_d;
    logic [BW-1:0]       req_be_q, req_be_d;
    logic [2:0]          req_prot_q, req_prot_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DW_APB-1:0]   prdata_q, prdata_d;
    logic                err_event_q, err_event_d;
    logic [1:0]          err_cause_q, err_cause_d;

    logic [CW-1:0]       ch_dec;
    logic                dec_miss;
    logic                ch_abandoned;
    logic                accept;
    logic                rsp_hit;
    logic                rsp_err;
    logic [N_CH-1:0]     cur_mask;
    logic                wdt_load;
    logic                wdt_en;
    logic                wdt_clr;
    logic                wdt_expire;

    if (N_CH > 1) begin : g_dec
        assign ch_dec   = s_apb.paddr[CH_SEL_LSB +: CW];
        assign dec_miss = int'(ch_dec) >= N_CH;
    end else begin : g_dec1
        assign ch_dec   = '0;
        assign dec_miss = 1'b0;
    end

    assign accept       = (state_q == IDLE) && s_apb.psel &&
                          s_apb.penable && !pready_q;
    assign ch_abandoned = !dec_miss && abandoned_q[ch_dec];
    assign rsp_hit      = rsp_valid[ch_q];
    assign rsp_err      = resp_is_err(rsp_resp[int'(ch_q)*2 +: 2]);

    // Only the channel being waited on is excluded from flag clearing.
    assign cur_mask = (state_q == WAIT) ? (N_CH'(1) << ch_q) : '0;

    assign wdt_load = accept && !dec_miss && !ch_abandoned;
    assign wdt_en   = (state_q == WAIT);
    assign wdt_clr  = (state_q == RESP);

    apb_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i    (apb_clk),
        .rst_ni   (sys_aresetn),
        .load_i   (wdt_load),
        .en_i     (wdt_en),
        .clr_i    (wdt_clr),
        .expire_o (wdt_expire)
    );

    always_ff @(posedge apb_clk or negedge sys_aresetn) begin
        if (!sys_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (dec_miss || ch_abandoned) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (rsp_hit || wdt_expire) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_valid_d = '0;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        req_prot_d  = req_prot_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = '0;
        err_event_d = 1'b0;
        err_cause_d = err_cause_q;
        ch_d        = ch_q;
        abandoned_d = abandoned_q & ~(rsp_valid & ~cur_mask);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_write_d = s_apb.pwrite;
                    req_addr_d  = s_apb.paddr;
                    req_wdata_d = s_apb.pwrite ? s_apb.pwdata : '0;
                    req_be_d    = s_apb.pwrite ? s_apb.pstrb : '0;
                    req_prot_d  = s_apb.pprot;
                    ch_d        = ch_dec;
                    if (dec_miss) begin
                        pready_d    = 1'b1;
                        pslverr_d   = 1'b1;
                        err_event_d = 1'b1;
                        err_cause_d = CAUSE_DECODE;
                    end else if (ch_abandoned) begin
                        pready_d    = 1'b1;
                        pslverr_d   = 1'b1;
                        err_event_d = 1'b1;
                        err_cause_d = CAUSE_TIMEOUT;
                    end else begin
                        req_valid_d = N_CH'(1) << ch_dec;
                    end
                end
            end
            WAIT: begin
                // A response arriving with the expiry wins.
                if (rsp_hit) begin
                    pready_d  = 1'b1;
                    pslverr_d = rsp_err;
                    prdata_d  = req_write_q ? '0 :
                                rsp_rdata[int'(ch_q)*DW_APB +: DW_APB];
                    if (rsp_err) begin
                        err_event_d = 1'b1;
                        err_cause_d = CAUSE_BACKEND;
                    end
                end else if (wdt_expire) begin
                    pready_d          = 1'b1;
                    pslverr_d         = 1'b1;
                    err_event_d       = 1'b1;
                    err_cause_d       = CAUSE_TIMEOUT;
                    abandoned_d[ch_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge apb_clk or negedge sys_aresetn) begin
        if (!sys_aresetn) begin
            req_valid_q <= '0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_prot_q  <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            err_event_q <= 1'b0;
            err_cause_q <= CAUSE_NONE;
            ch_q        <= '0;
            abandoned_q <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            req_prot_q  <= req_prot_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q    <= prdata_d;
            err_event_q <= err_event_d;
            err_cause_q <= err_cause_d;
            ch_q        <= ch_d;
            abandoned_q <= abandoned_d;
        end
    end

    assign req_valid     = req_valid_q;
    assign req_write     = req_write_q;
    assign req_addr      = req_addr_q;
    assign req_wdata     = req_wdata_q;
    assign req_be        = req_be_q;
    assign req_prot      = req_prot_q;
    assign s_apb.pready  = pready_q;
    assign s_apb.pslverr = pslverr_q;
    assign s_apb.prdata  = prdata_q;
    assign err_event     = err_event_q;
    assign err_cause     = err_cause_q;

endmodule
